// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the serial logic unit.
//   op_e    : logic operation select (AND, OR, XOR, NOR)
//   state_e : control FSM states (IDLE, BUSY, DONE)
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/logic_unit_serial_slice.sv
// logic_slice: combinational SLICE-bit bitwise operation select.
//   a, b : SLICE-bit operand slices
//   op   : operation select
//   y    : SLICE-bit result slice
module logic_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  op_e              op,
    output logic [SLICE-1:0] y
);

    always_comb begin
        y = op == OP_AND ? a & b :
            op == OP_OR  ? a | b :
            op == OP_XOR ? a ^ b : ~(a | b);
    end

endmodule

// File: rtl/logic_unit_serial.sv
// logic_unit_serial: multi-cycle bitwise logic unit, SLICE bits per clock.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   start   : request an operation (accepted only when idle)
//   op, a, b: operation and operands, captured with an accepted start
//   busy    : operation in progress
//   done    : one-cycle pulse; result and zero valid
//   result  : registered result, held until the next accepted start
//   zero    : result == 0, updated as done rises, then held
module logic_unit_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_e           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, res_n;
    op_e              op_q;
    logic [SLICE-1:0] y;
    logic [IW-1:0]    base;

    logic_slice #(.SLICE(SLICE)) u_slice (
        .a  (a_q[base +: SLICE]),
        .b  (b_q[base +: SLICE]),
        .op (op_q),
        .y  (y)
    );

    // The single slice engine is steered across the word by cnt; res_n is the
    // result as it will look after this cycle's slice write, so zero can be
    // taken from the fully written word on the final BUSY cycle.
    always_comb begin
        base = IW'(cnt) * IW'(SLICE);
        res_n = result;
        res_n[base +: SLICE] = y;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state == S_IDLE ? (start ? S_BUSY : S_IDLE) :
                  state == S_BUSY ? (cnt == LAST ? S_DONE : S_BUSY) : S_IDLE;
        busy = state == S_BUSY;
        done = state == S_DONE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_AND;
        end else if (state == S_IDLE && start) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= op_e'(op);
            result <= '0;
            cnt    <= '0;
        end else if (state == S_BUSY) begin
            result <= res_n;
            if (cnt == LAST) zero <= ~|res_n;
            else             cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_logic_unit_serial.sv
// tb_logic_unit_serial: self-checking bench for logic_unit_serial (SLICE=8 and SLICE=32).
module tb_logic_unit_serial;

    logic        clk = 1'b0;
    logic        reset_n, start, start2;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, zero, busy2, done2, zero2;
    logic [31:0] result, result2;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    logic_unit_serial #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero)
    );

    logic_unit_serial #(.WIDTH(32), .SLICE(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .start(start2), .op(op), .a(a), .b(b),
        .busy(busy2), .done(done2), .result(result2), .zero(zero2)
    );

    typedef struct {
        string       nm;
        logic [1:0]  op;
        logic [31:0] a, b, r;
        logic        z;
    } vec_t;

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Full operation with cycle-accurate handshake checks; operands are
    // scrambled every BUSY cycle to prove only the captured copies are used.
    task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er, input logic ez);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge clk);
            chk({nm, " busy/done"}, {30'd0, busy, done}, 32'd2);
            op = 2'($urandom); a = $urandom; b = $urandom;
        end
        @(negedge clk);
        chk({nm, " done pulse"}, {30'd0, busy, done}, 32'd1);
        chk({nm, " result"}, result, er);
        chk({nm, " zero"}, {31'd0, zero}, {31'd0, ez});
        @(negedge clk);
        chk({nm, " idle after"}, {30'd0, busy, done}, 32'd0);
        chk({nm, " result held"}, result, er);
    endtask

    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{"or",     2'd1, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0};
        tbl[1] = '{"and",    2'd0, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b1};
        tbl[2] = '{"xor",    2'd2, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1};
        tbl[3] = '{"nor",    2'd3, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        tbl[4] = '{"xor_mx", 2'd2, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 1'b0};

        reset_n = 1'b0; start = 1'b1; start2 = 1'b1;
        op = 2'd1; a = 32'hFFFF_FFFF; b = 32'h1;
        repeat (3) @(negedge clk);
        chk("reset busy/done", {30'd0, busy, done}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset zero", {31'd0, zero}, 32'd0);
        chk("reset32 busy/done", {30'd0, busy2, done2}, 32'd0);
        start = 1'b0; start2 = 1'b0; reset_n = 1'b1;

        foreach (tbl[i]) do_op(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].z);

        for (int i = 0; i < 20; i++) begin
            logic [1:0]  o;
            logic [31:0] x, y, r;
            o = 2'($urandom);
            x = $urandom;
            y = (i % 5 == 0) ? x : $urandom;
            r = model(o, x, y);
            do_op("rand", o, x, y, r, r == 32'd0);
        end

        // start held high: accepted in cycles 0, 6, 12; done in 5, 11, 17
        @(negedge clk);
        op = 2'd1; a = 32'hF0F0_0000; b = 32'h0000_0F0F; start = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            chk("cont busy/done", {30'd0, busy, done},
                {30'd0, (c % 6 >= 1 && c % 6 <= 4), (c % 6 == 5)});
            if (c % 6 == 5) chk("cont result", result, 32'hF0F0_0F0F);
        end
        start = 1'b0;
        @(negedge clk);
        chk("cont idle", {30'd0, busy, done}, 32'd0);

        // reset mid-operation, with zero previously set
        do_op("and_zero", 2'd0, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0, 1'b1);
        @(negedge clk);
        op = 2'd1; a = 32'hF0F0_0000; b = 32'h0000_0F0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort busy/done", {30'd0, busy, done}, 32'd0);
        chk("abort result", result, 32'd0);
        chk("abort zero", {31'd0, zero}, 32'd0);
        do_op("or_after_abort", 2'd1, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0);

        // single-slice instance
        @(negedge clk);
        op = 2'd1; a = 32'hF0F0_0000; b = 32'h0000_0F0F; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; op = 2'd0; a = 32'h0; b = 32'h0;
        chk("s32 busy/done c1", {30'd0, busy2, done2}, 32'd2);
        @(negedge clk);
        chk("s32 busy/done c2", {30'd0, busy2, done2}, 32'd1);
        chk("s32 result", result2, 32'hF0F0_0F0F);
        chk("s32 zero", {31'd0, zero2}, 32'd0);
        @(negedge clk);
        chk("s32 idle", {30'd0, busy2, done2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
